// File: rtl/mod_updown_counter_pkg.sv
// Shared definitions for the modulo-N up/down counter and its prescaler:
// mode and direction encodings plus a helper for sizing the prescaler.
package mod_updown_counter_pkg;

  // Counting behaviour when the terminal value is reached
  typedef enum logic {
    MODE_WRAP    = 1'b0,
    MODE_ONESHOT = 1'b1
  } countMode_e;

  // Counting direction as seen on the 'up' input
  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } countDir_e;

  // Width of a counter holding 0..p-1, never narrower than one bit so a
  // divide-by-one prescaler still has a legal register declaration.
  function automatic int prescWidth(input int p);
    if (p <= 2) begin
      return 1;
    end
    return $clog2(p);
  endfunction

endpackage

// File: rtl/mod_updown_counter_clk_prescaler.sv
// Enable divider for the counter: produces a tick on every PRESCALE-th
// enabled cycle. The phase survives enable dropping and is only cleared by
// reset or an explicit clear (used by the counter's load strobe).
module clk_prescaler
  import mod_updown_counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic CLK,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  generate
    if (PRESCALE <= 1) begin : gNoDivide
      // Divide-by-one keeps no state, so the clock, reset and clear have
      // nothing to act on; fold them into one deliberately unused net.
      logic unusedInputs;
      assign unusedInputs = ^{CLK, reset, clear};
      assign tick = enable;
    end else begin : gDivide
      localparam int PrescW = prescWidth(PRESCALE);
      localparam logic [PrescW-1:0] PrescLast = PrescW'(PRESCALE - 1);

      logic [PrescW-1:0] prescQ;
      logic [PrescW-1:0] prescD;

      // Next phase: clear wins, otherwise advance modulo PRESCALE while enabled
      always_comb begin
        prescD = prescQ;
        if (clear) begin
          prescD = '0;
        end else if (enable) begin
          if (prescQ == PrescLast) begin
            prescD = '0;
          end else begin
            prescD = prescQ + 1'b1;
          end
        end
      end

      // Phase register with synchronous active-low reset
      always_ff @(posedge CLK) begin
        if (!reset) begin
          prescQ <= '0;
        end else begin
          prescQ <= prescD;
        end
      end

      assign tick = enable & (prescQ == PrescLast);
    end
  endgenerate

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter with synchronous load, wrap or one-shot mode,
// built-in prescaler, registered overflow/underflow pulses and a
// combinational terminal-count output for cascading counters.
module mod_updown_counter
  import mod_updown_counter_pkg::*;
#(
  parameter int BITS     = 4,
  parameter int MODULUS  = 16,
  parameter int PRESCALE = 1
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic            enable,
  input  logic            up,
  input  logic            mode,
  input  logic            load,
  input  logic [BITS-1:0] load_value,
  output logic [BITS-1:0] count,
  output logic            overflow,
  output logic            underflow,
  output logic            done,
  output logic            tc
);

  generate
    if ((BITS < 1) || (MODULUS < 2) || (MODULUS > (2 ** BITS)) || (PRESCALE < 1)) begin : gBadParams
      $error("mod_updown_counter: illegal parameters BITS=%0d MODULUS=%0d PRESCALE=%0d",
             BITS, MODULUS, PRESCALE);
    end
  endgenerate

  localparam logic [BITS-1:0] CountMax = BITS'(MODULUS - 1);

  logic [BITS-1:0] countQ;
  logic [BITS-1:0] countD;
  logic            doneQ;
  logic            doneD;
  logic            overflowQ;
  logic            overflowD;
  logic            underflowQ;
  logic            underflowD;
  logic            stepTick;
  logic            atTop;
  logic            atBottom;

  // The prescaler only runs while counting is live; a finished one-shot
  // freezes its phase along with the count.
  clk_prescaler #(
    .PRESCALE (PRESCALE)
  ) uPrescaler (
    .CLK    (CLK),
    .reset  (reset),
    .enable (enable & ~doneQ),
    .clear  (load),
    .tick   (stepTick)
  );

  assign atTop    = (countQ == CountMax);
  assign atBottom = (countQ == '0);

  // Next-state: load beats a step; pulses default low so each lasts one cycle
  always_comb begin
    countD     = countQ;
    doneD      = doneQ;
    overflowD  = 1'b0;
    underflowD = 1'b0;
    if (load) begin
      countD = (load_value > CountMax) ? CountMax : load_value;
      doneD  = 1'b0;
    end else begin
      if (mode == MODE_WRAP) begin
        doneD = 1'b0;
      end
      if (stepTick) begin
        if (up == DIR_UP) begin
          if (!atTop) begin
            countD = countQ + 1'b1;
          end else begin
            overflowD = 1'b1;
            if (mode == MODE_WRAP) begin
              countD = '0;
            end else begin
              doneD = 1'b1;
            end
          end
        end else begin
          if (!atBottom) begin
            countD = countQ - 1'b1;
          end else begin
            underflowD = 1'b1;
            if (mode == MODE_WRAP) begin
              countD = CountMax;
            end else begin
              doneD = 1'b1;
            end
          end
        end
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!reset) begin
      countQ     <= '0;
      doneQ      <= 1'b0;
      overflowQ  <= 1'b0;
      underflowQ <= 1'b0;
    end else begin
      countQ     <= countD;
      doneQ      <= doneD;
      overflowQ  <= overflowD;
      underflowQ <= underflowD;
    end
  end

  assign count     = countQ;
  assign done      = doneQ;
  assign overflow  = overflowQ;
  assign underflow = underflowQ;

  // Carry into the next stage: this stage will roll over on the coming step
  assign tc = stepTick & ((up == DIR_UP) ? atTop : atBottom);

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench for mod_updown_counter. Three instances share one set of
// stimulus: a modulo-16 counter, a modulo-10 counter and a modulo-16 counter
// with a divide-by-3 prescaler. Each scenario resets and then checks only
// the instance it targets against hand-computed values.
module tb_mod_updown_counter;

  logic       CLK = 1'b0;
  logic       reset;
  logic       enable;
  logic       up;
  logic       mode;
  logic       load;
  logic [3:0] loadValue;

  logic [3:0] count16, count10, countP;
  logic       ov16, ov10, ovP;
  logic       un16, un10, unP;
  logic       done16, done10, doneP;
  logic       tc16, tc10, tcP;

  int checkCount = 0;
  int passCount  = 0;

  int t2Count [5] = '{2, 1, 0, 9, 8};
  int t2Under [5] = '{0, 0, 0, 1, 0};
  int t2Tc    [5] = '{0, 0, 1, 0, 0};
  int t4Count [6] = '{0, 0, 1, 1, 1, 2};

  // Free-running 10 ns clock
  always #5 CLK = ~CLK;

  mod_updown_counter #(.BITS(4), .MODULUS(16), .PRESCALE(1)) dut16 (
    .CLK(CLK), .reset(reset), .enable(enable), .up(up), .mode(mode),
    .load(load), .load_value(loadValue), .count(count16), .overflow(ov16),
    .underflow(un16), .done(done16), .tc(tc16));

  mod_updown_counter #(.BITS(4), .MODULUS(10), .PRESCALE(1)) dut10 (
    .CLK(CLK), .reset(reset), .enable(enable), .up(up), .mode(mode),
    .load(load), .load_value(loadValue), .count(count10), .overflow(ov10),
    .underflow(un10), .done(done10), .tc(tc10));

  mod_updown_counter #(.BITS(4), .MODULUS(16), .PRESCALE(3)) dutP (
    .CLK(CLK), .reset(reset), .enable(enable), .up(up), .mode(mode),
    .load(load), .load_value(loadValue), .count(countP), .overflow(ovP),
    .underflow(unP), .done(doneP), .tc(tcP));

  // Count one comparison and report it if it does not match
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed == expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, then return 1 ns after the edge that used them
  task automatic applyStimulus(input logic rstN, input logic en, input logic dirUp,
                               input logic md, input logic ld, input logic [3:0] lv);
    reset     = rstN;
    enable    = en;
    up        = dirUp;
    mode      = md;
    load      = ld;
    loadValue = lv;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; up = 1'b1; mode = 1'b0; load = 1'b0; loadValue = 4'd0;

    // Scenario 1: modulo-16 wrap up-count from a long reset
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    checkOutput("t1 reset count", int'(count16), 0);
    checkOutput("t1 reset ovf", int'(ov16), 0);
    checkOutput("t1 reset done", int'(done16), 0);
    checkOutput("t1 reset tc", int'(tc16), 0);
    for (int i = 1; i <= 15; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
      checkOutput("t1 count", int'(count16), i);
      checkOutput("t1 ovf low", int'(ov16), 0);
    end
    checkOutput("t1 tc at 15", int'(tc16), 1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    checkOutput("t1 wrap count", int'(count16), 0);
    checkOutput("t1 wrap ovf", int'(ov16), 1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    checkOutput("t1 after wrap count", int'(count16), 1);
    checkOutput("t1 after wrap ovf", int'(ov16), 0);

    // Scenario 2: modulo-10 down-count through zero in wrap mode
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3);
    checkOutput("t2 load count", int'(count10), 3);
    checkOutput("t2 load tc", int'(tc10), 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      checkOutput("t2 count", int'(count10), t2Count[i]);
      checkOutput("t2 udf", int'(un10), t2Under[i]);
      checkOutput("t2 tc", int'(tc10), t2Tc[i]);
    end

    // Scenario 3: modulo-10 one-shot up from 7, then reload to restart
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd7);
    checkOutput("t3 load count", int'(count10), 7);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    checkOutput("t3 count 8", int'(count10), 8);
    checkOutput("t3 done early", int'(done10), 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    checkOutput("t3 count 9", int'(count10), 9);
    checkOutput("t3 ovf before", int'(ov10), 0);
    checkOutput("t3 tc at 9", int'(tc10), 1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    checkOutput("t3 hold count", int'(count10), 9);
    checkOutput("t3 ovf pulse", int'(ov10), 1);
    checkOutput("t3 done set", int'(done10), 1);
    checkOutput("t3 tc while done", int'(tc10), 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    checkOutput("t3 still held", int'(count10), 9);
    checkOutput("t3 ovf dropped", int'(ov10), 0);
    checkOutput("t3 done held", int'(done10), 1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0);
    checkOutput("t3 reload count", int'(count10), 0);
    checkOutput("t3 reload done", int'(done10), 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    checkOutput("t3 resumed count", int'(count10), 1);

    // Scenario 4: divide-by-3 prescaler with an enable gap mid-phase
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
      checkOutput("t4 count", int'(countP), t4Count[i]);
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    checkOutput("t4 mid phase", int'(countP), 2);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    checkOutput("t4 frozen count", int'(countP), 2);
    checkOutput("t4 frozen ovf", int'(ovP), 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    checkOutput("t4 resume phase", int'(countP), 2);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    checkOutput("t4 resume step", int'(countP), 3);

    // Scenario 5: load clamping, load beating a step, load without enable
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd12);
    checkOutput("t5 clamp", int'(count10), 9);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd5);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    checkOutput("t5 count 6", int'(count10), 6);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd4);
    checkOutput("t5 load over step", int'(count10), 4);
    checkOutput("t5 no ovf", int'(ov10), 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd9);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd2);
    checkOutput("t5 load at top", int'(count10), 2);
    checkOutput("t5 load at top ovf", int'(ov10), 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd7);
    checkOutput("t5 load no enable", int'(count10), 7);

    // Scenario 6: reset beats load mid-count; a reset glitch between edges is ignored
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    checkOutput("t6 count 5", int'(count16), 5);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd9);
    checkOutput("t6 reset count", int'(count16), 0);
    checkOutput("t6 reset ovf", int'(ov16), 0);
    checkOutput("t6 reset udf", int'(un16), 0);
    checkOutput("t6 reset done", int'(done16), 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    checkOutput("t6 count 1", int'(count16), 1);
    #3 reset = 1'b0;
    #2 reset = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    checkOutput("t6 glitch ignored", int'(count16), 2);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
